// File: rtl/if_fetch_unit.sv
// Instruction-fetch stage: owns the fetch PC, runs a single-outstanding imem
// handshake and presents {pc, pc_4, instruction} to the IF/ID register.
module if_fetch_unit #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        stall,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ready,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  output logic [31:0] pc,
  output logic [31:0] pc_4,
  output logic [31:0] instruction,
  output logic        inst_valid,
  output logic        busy
);

  typedef enum logic [1:0] {
    S_REQ  = 2'd0,
    S_WAIT = 2'd1,
    S_OUT  = 2'd2
  } state_t;

  state_t      state_q, state_d;
  logic [31:0] fetch_pc_q, fetch_pc_d;
  logic        drop_q, drop_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] pc_4_q, pc_4_d;
  logic [31:0] instr_q, instr_d;
  logic        valid_q, valid_d;
  logic [31:0] redirect_aligned;

  assign redirect_aligned = redirect_pc & 32'hFFFF_FFFC;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= S_REQ;
      fetch_pc_q <= RESET_PC;
      drop_q     <= 1'b0;
      pc_q       <= '0;
      pc_4_q     <= '0;
      instr_q    <= NOP_INSTR;
      valid_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      fetch_pc_q <= fetch_pc_d;
      drop_q     <= drop_d;
      pc_q       <= pc_d;
      pc_4_q     <= pc_4_d;
      instr_q    <= instr_d;
      valid_q    <= valid_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    fetch_pc_d = fetch_pc_q;
    drop_d     = drop_q;
    pc_d       = pc_q;
    pc_4_d     = pc_4_q;
    instr_d    = instr_q;
    valid_d    = valid_q;

    case (state_q)
      S_REQ: begin
        if (imem_ready) begin
          state_d = S_WAIT;
          // a redirect on the accept edge makes the returning word stale
          drop_d  = redirect;
        end
      end
      S_WAIT: begin
        if (imem_rvalid) begin
          if (drop_q || redirect) begin
            drop_d  = 1'b0;
            state_d = S_REQ;
          end else begin
            pc_d    = fetch_pc_q;
            pc_4_d  = fetch_pc_q + 32'd4;
            instr_d = imem_rdata;
            valid_d = 1'b1;
            state_d = S_OUT;
          end
        end else if (redirect) begin
          drop_d = 1'b1;
        end
      end
      S_OUT: begin
        if (redirect || !stall) begin
          valid_d = 1'b0;
          instr_d = NOP_INSTR;
          state_d = S_REQ;
          if (!redirect) begin
            fetch_pc_d = fetch_pc_q + 32'd4;
          end
        end
      end
      default: begin
        state_d = S_REQ;
      end
    endcase

    // redirect target wins over every other fetch_pc update
    if (redirect) begin
      fetch_pc_d = redirect_aligned;
    end
  end

  assign imem_req    = reset_n && (state_q == S_REQ);
  assign imem_addr   = fetch_pc_q;
  assign pc          = pc_q;
  assign pc_4        = pc_4_q;
  assign instruction = instr_q;
  assign inst_valid  = valid_q;
  assign busy        = !valid_q;

endmodule

// File: tb/tb_if_fetch_unit.sv
// Scoreboard bench for if_fetch_unit: stimulus queues expected requests,
// presented instructions and status snapshots; a negedge monitor compares.
module tb_if_fetch_unit;

  localparam logic [31:0] NOP = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        reset_n, stall, redirect, imem_ready, imem_rvalid;
  logic [31:0] redirect_pc, imem_rdata;
  logic        imem_req, inst_valid, busy;
  logic [31:0] imem_addr, pc, pc_4, instruction;

  if_fetch_unit #(
    .RESET_PC (32'h0000_0000),
    .NOP_INSTR(NOP)
  ) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .stall      (stall),
    .redirect   (redirect),
    .redirect_pc(redirect_pc),
    .imem_req   (imem_req),
    .imem_addr  (imem_addr),
    .imem_ready (imem_ready),
    .imem_rvalid(imem_rvalid),
    .imem_rdata (imem_rdata),
    .pc         (pc),
    .pc_4       (pc_4),
    .instruction(instruction),
    .inst_valid (inst_valid),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    string       name;
    logic [31:0] pc, pc4, ins, addr;
    logic        v, b, r;
  } stat_t;

  typedef struct {
    logic [31:0] pc, pc4, ins;
  } out_t;

  logic [31:0] req_q[$];
  out_t        out_q[$];
  stat_t       stat_q[$];
  int          checks = 0;
  int          errors = 0;
  bit          done = 1'b0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %08h expected %08h", nm, act, exp);
    end
  endtask

  // Monitor: the only process that compares and steps the counters.
  initial begin
    stat_t s;
    out_t  o;
    logic [31:0] a;
    logic  prev_valid = 1'b0;
    forever begin
      @(negedge clk);
      while (stat_q.size() != 0) begin
        s = stat_q.pop_front();
        chk({s.name, ".pc"},    pc,          s.pc);
        chk({s.name, ".pc_4"},  pc_4,        s.pc4);
        chk({s.name, ".instr"}, instruction, s.ins);
        chk({s.name, ".addr"},  imem_addr,   s.addr);
        chk({s.name, ".valid"}, {31'd0, inst_valid}, {31'd0, s.v});
        chk({s.name, ".busy"},  {31'd0, busy},       {31'd0, s.b});
        chk({s.name, ".req"},   {31'd0, imem_req},   {31'd0, s.r});
      end
      if (imem_req && imem_ready) begin
        if (req_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL req_unexpected: accepted addr %08h, none expected", imem_addr);
        end else begin
          a = req_q.pop_front();
          chk("req_addr", imem_addr, a);
        end
      end
      if (inst_valid && !prev_valid) begin
        if (out_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL out_unexpected: pc %08h instr %08h, none expected", pc, instruction);
        end else begin
          o = out_q.pop_front();
          chk("out_pc",    pc,          o.pc);
          chk("out_pc_4",  pc_4,        o.pc4);
          chk("out_instr", instruction, o.ins);
        end
      end
      prev_valid = inst_valid;
      if (done) begin
        chk("req_pending", req_q.size(), 32'd0);
        chk("out_pending", out_q.size(), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL timeout: bench did not complete");
    $fatal(1);
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic stat(input string nm, input logic [31:0] p, input logic [31:0] p4,
                      input logic [31:0] ins, input logic [31:0] ad,
                      input logic v, input logic b, input logic r);
    stat_t s;
    s.name = nm; s.pc = p; s.pc4 = p4; s.ins = ins; s.addr = ad;
    s.v = v; s.b = b; s.r = r;
    stat_q.push_back(s);
  endtask

  // From S_REQ: accept at addr, return data next cycle; ends in S_OUT.
  task automatic fetch(input logic [31:0] addr, input logic [31:0] data);
    out_t o;
    o.pc  = addr;
    o.pc4 = addr + 32'd4;
    o.ins = data;
    imem_ready = 1'b1;
    req_q.push_back(addr);
    step();
    imem_ready  = 1'b0;
    imem_rvalid = 1'b1;
    imem_rdata  = data;
    out_q.push_back(o);
    step();
    imem_rvalid = 1'b0;
    imem_rdata  = 32'hX;
  endtask

  initial begin
    reset_n = 1'b0; stall = 1'b0; redirect = 1'b0; redirect_pc = '0;
    imem_ready = 1'b0; imem_rvalid = 1'b0; imem_rdata = '0;
    stat("reset", 32'h0, 32'h0, NOP, 32'h0, 1'b0, 1'b1, 1'b0);
    step();
    step();
    reset_n = 1'b1;
    stat("released", 32'h0, 32'h0, NOP, 32'h0, 1'b0, 1'b1, 1'b1);

    fetch(32'h0000_0000, 32'h0050_0093);
    stall = 1'b1;
    for (int i = 0; i < 4; i++) begin
      stat("stall_hold", 32'h0, 32'h4, 32'h0050_0093, 32'h0, 1'b1, 1'b0, 1'b0);
      step();
    end
    stall = 1'b0;
    step();

    fetch(32'h0000_0004, 32'h00A0_0113);
    step();

    // redirect while waiting, stale word arrives two cycles later
    imem_ready = 1'b1;
    req_q.push_back(32'h0000_0008);
    step();
    imem_ready = 1'b0; redirect = 1'b1; redirect_pc = 32'h0000_0103;
    step();
    redirect = 1'b0;
    step();
    imem_rvalid = 1'b1; imem_rdata = 32'hDEAD_BEEF;
    step();
    imem_rvalid = 1'b0;
    stat("wait_redir", 32'h4, 32'h8, NOP, 32'h0000_0100, 1'b0, 1'b1, 1'b1);
    fetch(32'h0000_0100, 32'h0000_0513);

    // redirect squashes a stalled instruction
    stall = 1'b1; redirect = 1'b1; redirect_pc = 32'h0000_0200;
    step();
    stall = 1'b0; redirect = 1'b0;
    stat("out_redir", 32'h100, 32'h104, NOP, 32'h0000_0200, 1'b0, 1'b1, 1'b1);
    fetch(32'h0000_0200, 32'h0010_0193);
    step();

    // redirect on the same edge the request is accepted
    imem_ready = 1'b1; redirect = 1'b1; redirect_pc = 32'h0000_0301;
    req_q.push_back(32'h0000_0204);
    step();
    imem_ready = 1'b0; redirect = 1'b0;
    imem_rvalid = 1'b1; imem_rdata = 32'hBAD0_BAD0;
    step();
    imem_rvalid = 1'b0;
    stat("acc_redir", 32'h200, 32'h204, NOP, 32'h0000_0300, 1'b0, 1'b1, 1'b1);
    fetch(32'h0000_0300, 32'h0020_0213);
    step();

    // unaccepted redirect in S_REQ, then wrap at the top of memory
    redirect = 1'b1; redirect_pc = 32'hFFFF_FFFE;
    step();
    redirect = 1'b0;
    stat("req_redir", 32'h300, 32'h304, NOP, 32'hFFFF_FFFC, 1'b0, 1'b1, 1'b1);
    fetch(32'hFFFF_FFFC, 32'h0030_0293);
    step();
    stat("wrap_addr", 32'hFFFF_FFFC, 32'h0, NOP, 32'h0, 1'b0, 1'b1, 1'b1);

    // async reset between edges while waiting for data
    imem_ready = 1'b1;
    req_q.push_back(32'h0000_0000);
    step();
    imem_ready = 1'b0;
    #2;
    reset_n = 1'b0;
    stat("mid_reset", 32'h0, 32'h0, NOP, 32'h0, 1'b0, 1'b1, 1'b0);
    step();
    reset_n = 1'b1;
    imem_rvalid = 1'b1; imem_rdata = 32'hFFFF_FFFF;
    step();
    imem_rvalid = 1'b0;
    stat("stray_rvalid", 32'h0, 32'h0, NOP, 32'h0, 1'b0, 1'b1, 1'b1);
    fetch(32'h0000_0000, 32'h0040_0313);
    step();
    step();
    done = 1'b1;
  end

endmodule
